// File: rtl/fp32_sqrt_unpack.sv
// fp32_sqrt_unpack: operand stage for the fp32 square-root datapath.
// Classifies a binary32 operand, normalizes subnormals and folds exponent
// parity into the radicand. The downstream root stage then sees a radicand
// in [1,4) and an exponent that is already halved.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high. A producer holds valid and data until that edge. The
// in_ready -> out_ready path is combinational.
module fp32_sqrt_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_class,
  output logic [7:0]  out_exp,
  output logic [25:0] out_rad,
  output logic [1:0]  out_rm,
  output logic [31:0] out_special,
  output logic        out_nv
);

  localparam logic [1:0] CLS_ZERO   = 2'd0;
  localparam logic [1:0] CLS_FINITE = 2'd1;
  localparam logic [1:0] CLS_INF    = 2'd2;
  localparam logic [1:0] CLS_NAN    = 2'd3;

  logic        sgn;
  logic [7:0]  ef;
  logic [22:0] fr;
  assign sgn = a[31];
  assign ef  = a[30:23];
  assign fr  = a[22:0];

  // Front-end classification and special result selection
  logic [1:0]  in_cls;
  logic [31:0] in_spec;
  logic        in_nv;
  always_comb begin
    in_cls  = CLS_FINITE;
    in_spec = 32'h0;
    in_nv   = 1'b0;
    if (ef == 8'd0 && fr == 23'd0) begin
      in_cls  = CLS_ZERO;
      in_spec = {sgn, 31'b0};
    end else if (ef == 8'hFF && fr != 23'd0) begin
      // Quiet NaN passes silently; a signalling NaN raises invalid
      in_cls  = CLS_NAN;
      in_spec = 32'h7FC00000;
      in_nv   = ~fr[22];
    end else if (sgn) begin
      in_cls  = CLS_NAN;
      in_spec = 32'h7FC00000;
      in_nv   = 1'b1;
    end else if (ef == 8'hFF) begin
      in_cls  = CLS_INF;
      in_spec = 32'h7F800000;
    end
  end

  // Leading-one position of the fraction (highest set bit wins)
  logic [4:0] lead;
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (fr[i]) lead = 5'(i);
    end
  end

  // Stage 1 state
  logic              s1_valid;
  logic [1:0]        s1_cls;
  logic [31:0]       s1_spec;
  logic              s1_nv;
  logic [1:0]        s1_rm;
  logic signed [8:0] s1_e;
  logic [23:0]       s1_m;
  logic [4:0]        s1_p;
  logic              s1_sub;

  // Stage 2 holds the outputs directly
  logic s2_valid;
  logic s1_adv;
  logic s1_load;

  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1 register: capture classification, raw mantissa and exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= 2'd0;
      s1_spec  <= 32'h0;
      s1_nv    <= 1'b0;
      s1_rm    <= 2'd0;
      s1_e     <= 9'sd0;
      s1_m     <= 24'd0;
      s1_p     <= 5'd0;
      s1_sub   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_cls   <= in_cls;
        s1_spec  <= in_spec;
        s1_nv    <= in_nv;
        s1_rm    <= rm;
        s1_e     <= $signed({1'b0, ef}) - 9'sd127;
        s1_m     <= {(ef != 8'd0), fr};
        s1_p     <= lead;
        s1_sub   <= (ef == 8'd0);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Subnormal shift, parity fold and exponent halving ahead of stage 2
  logic [23:0]       m_norm;
  logic signed [8:0] e_fin;
  logic [25:0]       rad_nx;
  logic [7:0]        exp_nx;
  always_comb begin
    m_norm = s1_m;
    e_fin  = s1_e;
    if (s1_sub) begin
      m_norm = s1_m << (5'd23 - s1_p);
      e_fin  = $signed({4'b0, s1_p}) - 9'sd149;
    end
    rad_nx = e_fin[0] ? {m_norm, 2'b00} : {1'b0, m_norm, 1'b0};
    // floor(e/2): arithmetic shift right by one, range fits 8 bits
    exp_nx = e_fin[8:1];
    if (s1_cls != CLS_FINITE) begin
      rad_nx = 26'd0;
      exp_nx = 8'd0;
    end
  end

  // Stage 2 register: output bundle, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_class   <= 2'd0;
      out_exp     <= 8'd0;
      out_rad     <= 26'd0;
      out_rm      <= 2'd0;
      out_special <= 32'h0;
      out_nv      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid    <= 1'b1;
        out_class   <= s1_cls;
        out_exp     <= exp_nx;
        out_rad     <= rad_nx;
        out_rm      <= s1_rm;
        out_special <= s1_spec;
        out_nv      <= s1_nv;
      end else if (s2_valid && out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
